// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the MIPS memory responder: access-size
// encoding, responder FSM states and data widths.
package mips_mem_pkg;

  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;

  localparam logic DT_WORD   = 1'b0;
  localparam logic DT_DOUBLE = 1'b1;

  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_WAIT = 2'd1,
    MR_RESP = 2'd2
  } mresp_state_t;

  function automatic logic [DWORD_W-1:0] zext_word(input logic [WORD_W-1:0] w);
    return {{(DWORD_W-WORD_W){1'b0}}, w};
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory port (master) and the
// memory responder (slave).
interface mem_responder_if
  import mips_mem_pkg::*;
#(
  parameter int AW = 32
);

  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic               req_dtype;
  logic [AW-1:0]      req_addr;
  logic [DWORD_W-1:0] req_wdata;
  logic               resp_valid;
  logic [DWORD_W-1:0] resp_rdata;
  logic               resp_err;

  modport master (
    output req_valid, req_write, req_dtype, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_dtype, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_responder_ram.sv
// DEPTH x 64-bit storage with independent low/high 32-bit lane write enables
// and a registered read port that holds its value until the next read.
module mem_responder_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic               clk,
  input  logic               we_lo,
  input  logic               we_hi,
  input  logic               re,
  input  logic [IW-1:0]      addr,
  input  logic [DWORD_W-1:0] wdata,
  output logic [DWORD_W-1:0] rdata
);

  logic [DWORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_lo) mem[addr][WORD_W-1:0]       <= wdata[WORD_W-1:0];
    if (we_hi) mem[addr][DWORD_W-1:WORD_W] <= wdata[DWORD_W-1:WORD_W];
    if (re)    rdata                       <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, WAIT wait states, commit, one-cycle
// response. Define MEMRESP_CHECK_EN to enable alignment and range error checks.
module mem_responder
  import mips_mem_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT  = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus
);

  // DEPTH is expected to be a power of two so the low index bits wrap cleanly.
  localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit         ZERO_WAIT = (WAIT == 0);
  localparam logic [3:0] WAIT_LD   = ZERO_WAIT ? 4'd0 : 4'(WAIT - 1);

  localparam logic [1:0] ST_IDLE = MR_IDLE;
  localparam logic [1:0] ST_WAIT = MR_WAIT;
  localparam logic [1:0] ST_RESP = MR_RESP;

  logic [1:0]         state;
  logic [3:0]         cnt;
  logic               accept;
  logic               commit;

  logic               lat_write;
  logic               lat_dtype;
  logic [AW-1:0]      lat_addr;
  logic [DWORD_W-1:0] lat_wdata;

  logic               c_write;
  logic               c_dtype;
  logic [AW-1:0]      c_addr;
  logic [DWORD_W-1:0] c_wdata;

  logic [AW-4:0]      idx_full;
  logic [IW-1:0]      idx;
  logic               err;

  logic               we_lo;
  logic               we_hi;
  logic               re;
  logic [DWORD_W-1:0] ram_wdata;
  logic [DWORD_W-1:0] ram_q;

  logic               rd_ok_p1;
  logic               rd_hi_p1;
  logic               rd_dbl_p1;
  logic               err_p1;

  assign accept = (state == ST_IDLE) && bus.req_valid;
  assign commit = ZERO_WAIT ? accept : ((state == ST_WAIT) && (cnt == 4'd0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: if (bus.req_valid) begin
          state <= ZERO_WAIT ? ST_RESP : ST_WAIT;
          cnt   <= WAIT_LD;
        end
        ST_WAIT: if (cnt == 4'd0) state <= ST_RESP;
                 else             cnt   <= cnt - 4'd1;
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= bus.req_write;
      lat_dtype <= bus.req_dtype;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
    end
  end

  // With no wait states the commit happens on the accept edge, straight from the bus.
  assign c_write = ZERO_WAIT ? bus.req_write : lat_write;
  assign c_dtype = ZERO_WAIT ? bus.req_dtype : lat_dtype;
  assign c_addr  = ZERO_WAIT ? bus.req_addr  : lat_addr;
  assign c_wdata = ZERO_WAIT ? bus.req_wdata : lat_wdata;

  assign idx_full = c_addr[AW-1:3];
  assign idx      = c_addr[3 +: IW];

`ifdef MEMRESP_CHECK_EN
  localparam logic [AW-4:0] DEPTH_LIM = (AW-3)'(DEPTH);
  assign err = ((c_dtype == DT_DOUBLE) ? (c_addr[2:0] != 3'd0)
                                       : (c_addr[1:0] != 2'd0))
             || (idx_full >= DEPTH_LIM);
`else
  logic unused_addr;
  assign unused_addr = ^{c_addr[1:0], idx_full};
  assign err         = 1'b0;
`endif

  assign we_lo     = commit && c_write && !err && ((c_dtype == DT_DOUBLE) || !c_addr[2]);
  assign we_hi     = commit && c_write && !err && ((c_dtype == DT_DOUBLE) ||  c_addr[2]);
  assign re        = commit && !c_write && !err;
  assign ram_wdata = (c_dtype == DT_DOUBLE) ? c_wdata
                                            : {c_wdata[WORD_W-1:0], c_wdata[WORD_W-1:0]};

  mem_responder_ram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk   (clk),
    .we_lo (we_lo),
    .we_hi (we_hi),
    .re    (re),
    .addr  (idx),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // Commit stage: response qualifiers captured alongside the RAM read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ok_p1  <= 1'b0;
      rd_hi_p1  <= 1'b0;
      rd_dbl_p1 <= 1'b0;
      err_p1    <= 1'b0;
    end else if (commit) begin
      rd_ok_p1  <= re;
      rd_hi_p1  <= c_addr[2];
      rd_dbl_p1 <= (c_dtype == DT_DOUBLE);
      err_p1    <= err;
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_err   = err_p1;
  assign bus.resp_rdata = !rd_ok_p1 ? '0
                        : rd_dbl_p1 ? ram_q
                        : zext_word(rd_hi_p1 ? ram_q[DWORD_W-1:WORD_W] : ram_q[WORD_W-1:0]);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests push expected responses,
// a negedge monitor pops and compares data, error flag and latency.
module tb_mem_responder;
  import mips_mem_pkg::*;

  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int WAIT  = 2;

`ifdef MEMRESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc   = 0;
  int   ncmp  = 0;
  int   nfail = 0;
  int   next_id = 0;
  exp_t sbq[$];
  exp_t e;

  logic [63:0] mem10;
  int          acc1, acc2, low;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if #(.AW(AW)) bus();

  mem_responder #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .WAIT  (WAIT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (sbq.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL resp_unexpected: got resp_valid at cycle %0d, expected none", cyc);
      end else begin
        e = sbq.pop_front();
        check64($sformatf("rdata#%0d", e.id), bus.resp_rdata, e.rdata);
        check64($sformatf("err#%0d", e.id), {63'd0, bus.resp_err}, {63'd0, e.err});
        check64($sformatf("latency#%0d", e.id), 64'(cyc), 64'(e.acc + WAIT));
      end
    end
  end

  // Called at a negedge; returns right after the accepting posedge.
  task automatic issue(input logic wr, input logic dt, input logic [AW-1:0] addr,
                       input logic [63:0] wd, input logic [63:0] er, input logic ee,
                       input bit push, output int acc);
    bus.req_write = wr;
    bus.req_dtype = dt;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      ncmp++;
      nfail++;
      $display("FAIL accept_timeout: got no req_ready for addr %h, expected accept", addr);
      $fatal(1, "accept timeout");
    end
    if (push) begin
      sbq.push_back('{er, ee, acc, next_id});
      next_id++;
    end
    @(posedge clk);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sbq.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      ncmp++;
      nfail++;
      $display("FAIL resp_timeout: got %0d pending responses, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic txn(input logic wr, input logic dt, input logic [AW-1:0] addr,
                     input logic [63:0] wd, input logic [63:0] er, input logic ee);
    int acc;
    issue(wr, dt, addr, wd, er, ee, 1'b1, acc);
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_dtype = DT_WORD;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    @(negedge clk);
    check64("rst_ready", {63'd0, bus.req_ready}, 64'd1);
    check64("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check64("rst_rdata", bus.resp_rdata, 64'd0);
    check64("rst_err", {63'd0, bus.resp_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    txn(1'b1, DT_DOUBLE, 32'h10, 64'h1122334455667788, 64'd0, 1'b0);
    mem10 = 64'h1122334455667788;
    txn(1'b0, DT_DOUBLE, 32'h10, 64'd0, mem10, 1'b0);
    txn(1'b1, DT_WORD,   32'h14, 64'h00000000AABBCCDD, 64'd0, 1'b0);
    mem10 = 64'hAABBCCDD55667788;
    txn(1'b0, DT_DOUBLE, 32'h10, 64'd0, mem10, 1'b0);
    txn(1'b0, DT_WORD,   32'h10, 64'd0, 64'h0000000055667788, 1'b0);
    txn(1'b0, DT_WORD,   32'h14, 64'd0, 64'h00000000AABBCCDD, 1'b0);

    // Misaligned accesses: rejected when checked, low bits ignored otherwise.
    txn(1'b0, DT_WORD, 32'h12, 64'd0, CHK ? 64'd0 : 64'h0000000055667788, CHK);
    txn(1'b1, DT_DOUBLE, 32'h14, 64'hDEADBEEFCAFEF00D, 64'd0, CHK);
    if (!CHK) mem10 = 64'hDEADBEEFCAFEF00D;
    txn(1'b0, DT_DOUBLE, 32'h10, 64'd0, mem10, 1'b0);

    txn(1'b1, DT_DOUBLE, 32'h0, 64'h0102030405060708, 64'd0, 1'b0);
    txn(1'b0, DT_DOUBLE, 32'(8 * DEPTH), 64'd0, CHK ? 64'd0 : 64'h0102030405060708, CHK);

    // Reset during the wait of a store aborts it.
    issue(1'b1, DT_DOUBLE, 32'h10, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, 1'b0, acc1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check64("abort_ready", {63'd0, bus.req_ready}, 64'd1);
    check64("abort_rdata", bus.resp_rdata, 64'd0);
    repeat (6) @(negedge clk);
    txn(1'b0, DT_DOUBLE, 32'h10, 64'd0, mem10, 1'b0);

    // Two loads with req_valid held throughout.
    issue(1'b0, DT_DOUBLE, 32'h10, 64'd0, mem10, 1'b0, 1'b1, acc1);
    @(negedge clk);
    bus.req_addr = 32'h0;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) break;
      low++;
      @(negedge clk);
    end
    issue(1'b0, DT_DOUBLE, 32'h0, 64'd0, 64'h0102030405060708, 1'b0, 1'b1, acc2);
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain();
    check64("b2b_spacing", 64'(acc2 - acc1), 64'(WAIT + 2));
    check64("b2b_ready_low", 64'(low), 64'(WAIT + 1));

    repeat (4) @(negedge clk);
    check64("sb_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
